// File: rtl/psum_collector_pkg.sv
// Shared types and sizing for the partial-sum collection path.
// Imported by the collector and its buffer.
package psum_collector_pkg;

  localparam int unsigned PSUM_WIDTH    = 16;
  localparam int unsigned L1_OFMAP_SIZE = 16;
  localparam int unsigned L2_OFMAP_SIZE = 8;
  localparam int unsigned L3_OFMAP_SIZE = 4;

  localparam int unsigned BUF_DEPTH  = 256;
  localparam int unsigned BUF_ADDR_W = 8;

  typedef enum logic [1:0] {
    MODE1,
    MODE2,
    MODE3,
    MODE4
  } OP_MODE;

  typedef enum logic [1:0] {
    STAGE_IDLE,
    STAGE_LOAD,
    CONV,
    STAGE_DRAIN
  } OP_STAGE;

  typedef struct packed {
    logic                         valid;
    logic signed [PSUM_WIDTH-1:0] psum;
    logic [1:0]                   filter_idx;
  } PSUM_PACKET;

  // Optional ReLU applied on the way into the buffer.
  function automatic logic [PSUM_WIDTH-1:0] relu_clamp(input logic [PSUM_WIDTH-1:0] v,
                                                       input logic                  en);
    return (en && v[PSUM_WIDTH-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/psum_buf.sv
// Simple dual-port psum storage: one write port, one registered read port.
// A same-address read and write returns the old contents.
module psum_buf #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Collects filter-interleaved partial sums of one ofmap pass into a 256-entry buffer
// and serves random-access readout.
module psum_collector
  import psum_collector_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  OP_MODE                mode_in,
  input  logic                  change_mode,
  input  logic                  conv_continue,
  input  OP_STAGE               op_stage_in,
  input  PSUM_PACKET            psum_in,
  output logic                  psum_ack,
  input  logic                  relu_en,
  input  logic                  rd_en,
  input  logic [7:0]            rd_addr,
  output logic [PSUM_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  collect_done,
  output logic                  seq_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0] state_q, state_d;
  OP_MODE     cur_mode;
  logic [1:0] exp_filter;
  logic [5:0] psum_idx;
  logic [5:0] psum_idx_max;

  logic clear;
  logic in_conv;
  logic accept;
  logic last_accept;

  logic [BUF_ADDR_W-1:0] wr_addr;
  logic [PSUM_WIDTH-1:0] wr_data;

  assign clear   = conv_continue | change_mode;
  assign in_conv = (op_stage_in == CONV);

  // Clearing wins over a simultaneous accept, so ack is suppressed outright.
  assign psum_ack    = psum_in.valid & in_conv & (state_q != ST_DONE) & ~clear;
  assign accept      = psum_ack;
  assign last_accept = accept & (exp_filter == 2'd3) & (psum_idx == psum_idx_max);

  assign wr_addr = {psum_idx, exp_filter};
  assign wr_data = relu_clamp(psum_in.psum, relu_en);

  always_comb begin
    unique case (cur_mode)
      MODE1, MODE2: psum_idx_max = 6'(L1_OFMAP_SIZE - 1);
      MODE3:        psum_idx_max = 6'(L2_OFMAP_SIZE - 1);
      default:      psum_idx_max = 6'(L3_OFMAP_SIZE - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (last_accept) begin
          state_d = ST_DONE;
        end else if (in_conv) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (last_accept) begin
          state_d = ST_DONE;
        end else if (!in_conv) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode <= MODE1;
    end else if (change_mode) begin
      cur_mode <= mode_in;
    end
  end

  // Counters survive a stage excursion out of CONV; only clear/reset rewinds them.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_filter   <= 2'd0;
      psum_idx     <= 6'd0;
      collect_done <= 1'b0;
      seq_err      <= 1'b0;
    end else if (clear) begin
      exp_filter   <= 2'd0;
      psum_idx     <= 6'd0;
      collect_done <= 1'b0;
      seq_err      <= 1'b0;
    end else if (accept) begin
      exp_filter <= exp_filter + 2'd1;
      if (psum_in.filter_idx != exp_filter) begin
        seq_err <= 1'b1;
      end
      if (exp_filter == 2'd3) begin
        if (psum_idx == psum_idx_max) begin
          collect_done <= 1'b1;
        end else begin
          psum_idx <= psum_idx + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  psum_buf #(
    .Width(PSUM_WIDTH),
    .Depth(BUF_DEPTH),
    .AddrW(BUF_ADDR_W)
  ) u_psum_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (accept),
    .waddr(wr_addr),
    .wdata(wr_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: mode_in  input  OP_MODE  layer mode, latched on change_mode.
REQ-004 SHALL have port: change_mode  input  1  latch mode_in, clear collection state.
REQ-005 SHALL have port: conv_continue  input  1  start new ofmap pass, clear collection state.
REQ-006 SHALL have port: op_stage_in  input  OP_STAGE  collection enabled only in CONV.
REQ-007 SHALL have port: psum_in  input  PSUM_PACKET  incoming psum: valid, psum (signed PSUM_WIDTH), filter_idx[1:0].
REQ-008 SHALL have port: psum_ack  output  1  accept strobe for psum_in.
REQ-009 SHALL have port: relu_en  input  1  clamp negative psums to 0 on store.
REQ-010 SHALL have port: rd_en  input  1  readout request.
REQ-011 SHALL have port: rd_addr  input  8  readout address {psum_idx[5:0], filter_idx[1:0]}.
REQ-012 SHALL have port: rd_data  output  PSUM_WIDTH  readout data.
REQ-013 SHALL have port: rd_valid  output  1  rd_data valid.
REQ-014 SHALL have port: collect_done  output  1  all psums of current ofmap stored.
REQ-015 SHALL have port: seq_err  output  1  sticky: received filter_idx differed from expected.

Function
REQ-016 SHALL hold cur_mode (reset MODE1), updated from mode_in on change_mode.
REQ-017 SHALL set psum_idx_max = L1_OFMAP_SIZE-1 for MODE1/MODE2, L2_OFMAP_SIZE-1 for MODE3, L3_OFMAP_SIZE-1 otherwise.
REQ-018 SHALL implement states IDLE, COLLECT, DONE; IDLE->COLLECT when op_stage_in==CONV; COLLECT->IDLE when op_stage_in!=CONV (counters kept); COLLECT->DONE on final accept; DONE->IDLE on conv_continue or change_mode.
REQ-019 SHALL drive psum_ack = psum_in.valid & op_stage_in==CONV & state!=DONE & ~conv_continue & ~change_mode (combinational, same cycle).
REQ-020 SHALL, on each accept, write the psum to buffer address {psum_idx, exp_filter} at the clock edge.
REQ-021 SHALL store 0 when relu_en=1 and psum is negative, else the psum unchanged.
REQ-022 SHALL advance exp_filter 0..3 mod 4 per accept, incrementing psum_idx when exp_filter wraps from 3.
REQ-023 SHALL enter DONE and assert collect_done on the accept with exp_filter==3 and psum_idx==psum_idx_max; the 6-bit psum_idx SHALL not increment past psum_idx_max.
REQ-024 SHALL set seq_err when psum_in.filter_idx!=exp_filter on an accept; the psum is still stored at the expected address.
REQ-025 SHALL clear exp_filter, psum_idx, collect_done and seq_err on conv_continue or change_mode; clear has priority over a simultaneous accept (no ack, no write).
REQ-026 SHALL return buffer[rd_addr] on rd_data with rd_valid=1 exactly one cycle after rd_en; otherwise rd_valid=0 and rd_data holds its last value.
REQ-027 SHALL, on a same-cycle read and write to one address, return the old contents.
REQ-028 SHALL read in any state, including mid-collection.

Reset
REQ-029 SHALL reset state=IDLE, cur_mode=MODE1, exp_filter=0, psum_idx=0, collect_done=0, seq_err=0, rd_valid=0, rd_data=0.
REQ-030 SHALL not reset buffer contents; a reset mid-collection discards progress and ack resumes from address 0.

Structure
REQ-031 SHALL take OP_MODE, OP_STAGE, PSUM_PACKET, PSUM_WIDTH and L1/L2/L3_OFMAP_SIZE from the shared package; the collector state enum SHALL be local.
REQ-032 SHALL instantiate one sub-module psum_buf: 256 x PSUM_WIDTH, 1 write and 1 read port, registered 1-cycle read.

Verification
REQ-033 SHALL cover MODE1 full pass with the zero-psum generator as source: L1_OFMAP_SIZE*4 acks, then collect_done=1 and psum_ack=0 with valid held.
REQ-034 SHALL cover relu_en=1 with psums -5, 7 on filters 0 and 1: readout addr 0 -> 0, addr 1 -> 7, rd_valid one cycle after rd_en.
REQ-035 SHALL cover filter_idx=2 sent when 0 is expected: seq_err=1 and data at addr 0; conv_continue clears seq_err.
REQ-036 SHALL cover conv_continue in the same cycle as valid: psum_ack=0, no write, next accept lands at addr 0.
REQ-037 SHALL cover change_mode to MODE3 after DONE: cur_mode=MODE3 and done after L2_OFMAP_SIZE*4 accepts.
REQ-038 SHALL cover op_stage_in leaving CONV mid-pass for 3 cycles: no acks, then resume at the next expected address.
